// File: rtl/boot_pkg.sv
// Shared definitions for the boot memory writer: target codes,
// FSM states and the width of one buffered write entry.
package boot_pkg;

  typedef enum logic [1:0] {
    TGT_RAM1 = 2'd0,
    TGT_RAM2 = 2'd1,
    TGT_RAM3 = 2'd2,
    TGT_MAIN = 2'd3
  } tgt_e;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int TGT_W  = 2;
  localparam int DATA_W = 32;

  function automatic int entry_w(input int addr_w);
    return TGT_W + addr_w + DATA_W;
  endfunction

endpackage

// File: rtl/boot_wr_fifo.sv
// Synchronous write buffer with registered storage; a push into a
// full buffer still succeeds when the head is popped in the same cycle.
module boot_wr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 56
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_push_ok
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr;
  logic [PW-1:0]    r_rd;
  logic [PW:0]      r_cnt;
  logic             w_pop;
  logic             w_push;

  assign o_empty   = (r_cnt == '0);
  assign o_full    = (r_cnt == (PW+1)'(DEPTH));
  assign w_pop     = i_pop && !o_empty;
  assign w_push    = i_push && (!o_full || w_pop);
  assign o_push_ok = w_push;
  assign o_head    = r_mem[r_rd];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + PW'(1);
      if (w_pop)  r_rd <= r_rd + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + (PW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (PW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // When full, r_wr equals r_rd: the slot being overwritten is the one popped.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end

endmodule

// File: rtl/boot_mem_writer.sv
// Converts loader init strobes into a buffered req/gnt write stream,
// tracks committed checksum/count and signals boot completion.
module boot_mem_writer #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 22,
  parameter int CNT_W      = 20
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              loader_rdy,
  input  logic [ADDR_W-1:0] init_ram_addr,
  input  logic [31:0]       init_ram_data,
  input  logic              init_ram1_wr,
  input  logic              init_ram2_wr,
  input  logic              init_ram3_wr,
  input  logic              init_main_wr,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic [1:0]        mem_tgt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  output logic              boot_done,
  output logic [31:0]       boot_checksum,
  output logic [CNT_W-1:0]  boot_word_cnt,
  output logic              overflow_err,
  output logic              multi_sel_err
);

  import boot_pkg::*;

  localparam int ENTRY_W = entry_w(ADDR_W);

  state_e             r_state;
  state_e             w_state_nx;
  logic [31:0]        r_cksum;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ovf;
  logic               r_msel;

  logic [3:0]         w_stb;
  logic               w_any;
  logic               w_multi;
  tgt_e               w_tgt;
  logic               w_accept;
  logic               w_pop;
  logic               w_push_ok;
  logic               w_full;
  logic               w_empty;
  logic [ENTRY_W-1:0] w_head;

  assign w_stb    = {init_main_wr, init_ram3_wr, init_ram2_wr, init_ram1_wr};
  assign w_any    = |w_stb;
  assign w_multi  = (w_stb & (w_stb - 4'd1)) != 4'd0;
  assign w_accept = w_any && (r_state != DONE);
  assign w_pop    = !w_empty && mem_gnt;

  always_comb begin
    w_tgt = TGT_MAIN;
    priority case (1'b1)
      init_ram1_wr: w_tgt = TGT_RAM1;
      init_ram2_wr: w_tgt = TGT_RAM2;
      init_ram3_wr: w_tgt = TGT_RAM3;
      default:      w_tgt = TGT_MAIN;
    endcase
  end

  boot_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .i_clk     (sys_clk),
    .i_rst     (sys_rst),
    .i_push    (w_accept),
    .i_pop     (mem_gnt),
    .i_data    ({w_tgt, init_ram_addr, init_ram_data}),
    .o_head    (w_head),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_push_ok (w_push_ok)
  );

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      LOAD:    if (loader_rdy) w_state_nx = DRAIN;
      DRAIN:   if (w_empty && !w_any && !w_pop) w_state_nx = DONE;
      DONE:    w_state_nx = DONE;
      default: w_state_nx = LOAD;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state <= LOAD;
      r_cksum <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
      r_msel  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      if (w_pop) begin
        r_cksum <= r_cksum + w_head[31:0];
        if (r_cnt != {CNT_W{1'b1}}) r_cnt <= r_cnt + CNT_W'(1);
      end
      // Strobes after DONE break the loader protocol and are dropped.
      if ((w_accept && !w_push_ok) || (w_any && r_state == DONE))
        r_ovf <= 1'b1;
      if (w_accept && w_multi) r_msel <= 1'b1;
    end
  end

  assign mem_req       = !w_empty;
  assign mem_tgt       = mem_req ? w_head[ENTRY_W-1 -: TGT_W] : 2'd0;
  assign mem_addr      = mem_req ? w_head[ADDR_W+31 -: ADDR_W] : '0;
  assign mem_wdata     = mem_req ? w_head[31:0] : 32'd0;
  assign mem_be        = mem_req ? 4'hF : 4'h0;
  assign boot_done     = (r_state == DONE);
  assign boot_checksum = r_cksum;
  assign boot_word_cnt = r_cnt;
  assign overflow_err  = r_ovf;
  assign multi_sel_err = r_msel;

  logic w_unused;
  assign w_unused = w_full;

endmodule

// File: tb/tb_boot_mem_writer.sv
// Directed plus randomized bench for boot_mem_writer against a
// queue-based behavioural model checked every cycle.
module tb_boot_mem_writer;

  localparam int DEPTH = 4;
  localparam int AW    = 22;
  localparam int CW    = 20;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rdy = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [31:0]   data = '0;
  logic          s1 = 1'b0, s2 = 1'b0, s3 = 1'b0, sm = 1'b0;
  logic          gnt = 1'b0;

  logic          mem_req;
  logic [1:0]    mem_tgt;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_be;
  logic          boot_done;
  logic [31:0]   boot_checksum;
  logic [CW-1:0] boot_word_cnt;
  logic          overflow_err;
  logic          multi_sel_err;

  boot_mem_writer #(
    .FIFO_DEPTH (DEPTH),
    .ADDR_W     (AW),
    .CNT_W      (CW)
  ) dut (
    .sys_clk       (clk),
    .sys_rst       (rst),
    .loader_rdy    (rdy),
    .init_ram_addr (addr),
    .init_ram_data (data),
    .init_ram1_wr  (s1),
    .init_ram2_wr  (s2),
    .init_ram3_wr  (s3),
    .init_main_wr  (sm),
    .mem_req       (mem_req),
    .mem_gnt       (gnt),
    .mem_tgt       (mem_tgt),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_be        (mem_be),
    .boot_done     (boot_done),
    .boot_checksum (boot_checksum),
    .boot_word_cnt (boot_word_cnt),
    .overflow_err  (overflow_err),
    .multi_sel_err (multi_sel_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string n, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", n, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue of pending writes plus running totals.
  typedef struct {
    logic [1:0]    t;
    logic [AW-1:0] a;
    logic [31:0]   d;
  } ent_t;

  ent_t        q[$];
  ent_t        m_e;
  logic [31:0] m_ck;
  int          m_cnt;
  bit          m_ovf, m_msel, m_pop, m_any, m_ok;
  int          m_ph;
  bit          chk_en = 1'b0;

  always @(posedge clk) begin
    m_any = s1 | s2 | s3 | sm;
    if (rst) begin
      q.delete();
      m_ck = 0; m_cnt = 0; m_ovf = 0; m_msel = 0; m_ph = 0;
    end else begin
      m_pop = (q.size() != 0) && gnt;
      m_ok  = 0;
      if (m_any && m_ph == 2) m_ovf = 1;
      else if (m_any) begin
        m_e.t = s1 ? 2'd0 : s2 ? 2'd1 : s3 ? 2'd2 : 2'd3;
        m_e.a = addr;
        m_e.d = data;
        if (int'(s1) + int'(s2) + int'(s3) + int'(sm) > 1) m_msel = 1;
        if (q.size() < DEPTH || m_pop) m_ok = 1;
        else m_ovf = 1;
      end
      if (m_ph == 1 && q.size() == 0 && !m_any && !m_pop) m_ph = 2;
      else if (m_ph == 0 && rdy) m_ph = 1;
      if (m_pop) begin
        m_ck = m_ck + q[0].d;
        if (m_cnt < (1 << CW) - 1) m_cnt++;
        void'(q.pop_front());
      end
      if (m_ok) q.push_back(m_e);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic          er;
      logic [1:0]    et;
      logic [AW-1:0] ea;
      logic [31:0]   ed;
      er = (q.size() != 0);
      et = er ? q[0].t : 2'd0;
      ea = er ? q[0].a : '0;
      ed = er ? q[0].d : 32'd0;
      check("req", 64'(mem_req), 64'(er));
      check("tgt", 64'(mem_tgt), 64'(et));
      check("addr", 64'(mem_addr), 64'(ea));
      check("wdata", 64'(mem_wdata), 64'(ed));
      check("be", 64'(mem_be), er ? 64'hF : 64'h0);
      check("done", 64'(boot_done), 64'(m_ph == 2));
      check("cksum", 64'(boot_checksum), 64'(m_ck));
      check("cnt", 64'(boot_word_cnt), 64'(m_cnt));
      check("ovf", 64'(overflow_err), 64'(m_ovf));
      check("msel", 64'(multi_sel_err), 64'(m_msel));
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; rdy = 1'b0; gnt = 1'b0;
    {sm, s3, s2, s1} = 4'b0;
    cyc(1);
    rst = 1'b0;
  endtask

  task automatic wr(input logic [3:0] mask, input logic [AW-1:0] a,
                    input logic [31:0] d);
    {sm, s3, s2, s1} = mask;
    addr = a;
    data = d;
    cyc(1);
    {sm, s3, s2, s1} = 4'b0;
  endtask

  task automatic wait_done(input int maxc, input string n);
    int k = 0;
    while (!boot_done && k < maxc) begin
      cyc(1);
      k++;
    end
    check(n, 64'(boot_done), 64'd1);
  endtask

  logic [3:0] mask;

  initial begin
    do_reset();
    chk_en = 1'b1;
    check("rst_req", 64'(mem_req), 64'd0);
    check("rst_done", 64'(boot_done), 64'd0);
    check("rst_cksum", 64'(boot_checksum), 64'd0);

    // nominal stream
    gnt = 1'b1;
    wr(4'b0001, 22'd0, 32'h11111111);
    wr(4'b0001, 22'd1, 32'h22222222);
    wr(4'b0001, 22'd2, 32'h33333333);
    rdy = 1'b1;
    wait_done(20, "nom_done");
    check("nom_cksum", 64'(boot_checksum), 64'h66666666);
    check("nom_model_cksum", 64'(m_ck), 64'h66666666);
    check("nom_cnt", 64'(boot_word_cnt), 64'd3);

    // back-pressure
    do_reset();
    for (int i = 0; i < 4; i++) begin
      wr(4'b1000, 22'(16 + i), 32'(32'hA0 + i));
      cyc(1);
    end
    check("bp_req", 64'(mem_req), 64'd1);
    check("bp_addr0", 64'(mem_addr), 64'd16);
    cyc(12);
    check("bp_addr1", 64'(mem_addr), 64'd16);
    check("bp_data1", 64'(mem_wdata), 64'hA0);
    gnt = 1'b1;
    cyc(4);
    check("bp_drained", 64'(mem_req), 64'd0);
    check("bp_cnt", 64'(boot_word_cnt), 64'd4);
    check("bp_cksum", 64'(boot_checksum), 64'h286);
    check("bp_ovf", 64'(overflow_err), 64'd0);

    // overflow
    do_reset();
    for (int i = 1; i <= 5; i++) wr(4'b1000, 22'(i), 32'(i));
    check("of_ovf", 64'(overflow_err), 64'd1);
    gnt = 1'b1;
    cyc(5);
    check("of_cksum", 64'(boot_checksum), 64'd10);
    check("of_model_cksum", 64'(m_ck), 64'd10);
    check("of_cnt", 64'(boot_word_cnt), 64'd4);

    // full with simultaneous pop
    do_reset();
    for (int i = 1; i <= 4; i++) wr(4'b0100, 22'(i), 32'(i));
    gnt = 1'b1;
    wr(4'b0001, 22'd9, 32'd5);
    check("fp_ovf", 64'(overflow_err), 64'd0);
    cyc(5);
    check("fp_cnt", 64'(boot_word_cnt), 64'd5);
    check("fp_cksum", 64'(boot_checksum), 64'd15);

    // multi-strobe
    do_reset();
    wr(4'b1010, 22'h5, 32'hDEADBEEF);
    check("ms_req", 64'(mem_req), 64'd1);
    check("ms_tgt", 64'(mem_tgt), 64'd1);
    check("ms_addr", 64'(mem_addr), 64'd5);
    check("ms_flag", 64'(multi_sel_err), 64'd1);
    gnt = 1'b1;
    cyc(2);
    check("ms_cnt", 64'(boot_word_cnt), 64'd1);

    // reset mid-drain
    do_reset();
    wr(4'b1010, 22'd1, 32'h100);
    wr(4'b0001, 22'd2, 32'h200);
    wr(4'b0010, 22'd3, 32'h300);
    wr(4'b0100, 22'd4, 32'h400);
    gnt = 1'b1;
    cyc(1);
    gnt = 1'b0;
    rdy = 1'b1;
    cyc(2);
    check("rd_pre_cksum", 64'(boot_checksum), 64'h100);
    check("rd_pre_done", 64'(boot_done), 64'd0);
    do_reset();
    check("rd_req", 64'(mem_req), 64'd0);
    check("rd_done", 64'(boot_done), 64'd0);
    check("rd_cksum", 64'(boot_checksum), 64'd0);
    check("rd_msel", 64'(multi_sel_err), 64'd0);
    rdy = 1'b1;
    cyc(1);
    check("rd_done1", 64'(boot_done), 64'd0);
    cyc(1);
    check("rd_done2", 64'(boot_done), 64'd1);
    wr(4'b0001, 22'd7, 32'h7);
    check("done_strobe_ovf", 64'(overflow_err), 64'd1);
    check("done_strobe_req", 64'(mem_req), 64'd0);

    // randomized traffic
    do_reset();
    for (int c = 0; c < 600; c++) begin
      gnt = ($urandom_range(0, 99) < (c < 200 ? 20 : 70));
      if (c < 500 && $urandom_range(0, 99) < 45) begin
        if ($urandom_range(0, 9) == 0) mask = 4'($urandom_range(1, 15));
        else mask = 4'b0001 << $urandom_range(0, 3);
        {sm, s3, s2, s1} = mask;
        addr = AW'($urandom());
        data = $urandom();
      end else begin
        {sm, s3, s2, s1} = 4'b0;
      end
      if (c == 450) rdy = 1'b1;
      cyc(1);
    end
    {sm, s3, s2, s1} = 4'b0;
    gnt = 1'b1;
    wait_done(50, "rnd_done");
    cyc(2);
    chk_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
